// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types and helpers for the hex scan display driver
package hex_disp_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DEFAULT_DIGITS = 4;

    function automatic logic nibble_is_zero(input logic [3:0] nib);
        return nib == 4'h0;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter that flags terminal count at zero
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Loading N-1 on entry makes the owning state last exactly N cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc    = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - frame-synchronous multiplexed hex driver for a 7-segment display
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int DIGITS       = DEFAULT_DIGITS,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  blank_lz,
    output logic [3:0]            digit_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  digit_blank,
    output logic                  frame_done
);

    localparam int MAX_COUNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT);
    localparam int IW        = $clog2(DIGITS);

    localparam logic [CW-1:0] DRIVE_LOAD = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

    scan_state_t           r_state;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_display;
    logic [4*DIGITS-1:0]   r_pending;
    logic                  r_pend_full;
    logic [3:0]            r_digit_out;
    logic [DIGITS-1:0]     r_digit_sel;
    logic                  r_digit_blank;
    logic                  r_frame_done;

    logic                  w_tc;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_load_val;
    logic [DIGITS-1:0]     w_lz_mask;
    logic                  w_xfer;

    assign w_load_val = (r_state == GUARD) ? DRIVE_LOAD : GUARD_LOAD;
    assign w_xfer     = value_valid && !r_pend_full;

    scan_timer #(
        .WIDTH      (CW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tc),
        .i_load_val (w_load_val),
        .o_tc       (w_tc),
        .o_count    (w_count)
    );

    always_comb begin
        logic v_zero_run;
        w_lz_mask  = '0;
        v_zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_zero_run   = v_zero_run & nibble_is_zero(r_display[4*i +: 4]);
            w_lz_mask[i] = blank_lz & v_zero_run;
        end
    end

    // frame_done is raised one cycle early so it is high during the last DRIVE
    // cycle; this is why REFRESH_DIV must be at least 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= GUARD;
            r_idx         <= '0;
            r_digit_out   <= 4'h0;
            r_digit_sel   <= '1;
            r_digit_blank <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= (r_state == DRIVE) && (r_idx == LAST_IDX) && (w_count == CW'(1));
            if (w_tc) begin
                if (r_state == GUARD) begin
                    r_state       <= DRIVE;
                    r_digit_sel   <= ~(DIGITS'(1) << r_idx);
                    r_digit_out   <= r_display[{r_idx, 2'b00} +: 4];
                    r_digit_blank <= w_lz_mask[r_idx];
                end else begin
                    r_state       <= GUARD;
                    r_digit_sel   <= '1;
                    r_digit_blank <= 1'b1;
                    r_idx         <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
            end
        end
    end

    // A transfer landing on the frame boundary bypasses pending entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_display   <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else if (r_frame_done) begin
            if (w_xfer) begin
                r_display <= value_in;
            end else if (r_pend_full) begin
                r_display   <= r_pending;
                r_pend_full <= 1'b0;
            end
        end else if (w_xfer) begin
            r_pending   <= value_in;
            r_pend_full <= 1'b1;
        end
    end

    assign value_ready = !r_pend_full;
    assign digit_out   = r_digit_out;
    assign digit_sel   = r_digit_sel;
    assign digit_blank = r_digit_blank;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - directed self-checking bench for hex_scan_driver
module tb_hex_scan_driver;
    import hex_disp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  digit_sel;
    logic        digit_blank;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int mon_viol = 0;
    int mon_cycles = 0;

    logic [3:0] obs_nib [4];
    int         obs_cnt [4];
    logic [3:0] obs_blank;
    logic [15:0] obs_val;
    int obs_guard, obs_unstable, obs_fd, obs_fd_pos, obs_acc, obs_ready_low;
    logic obs_timing_ok;

    hex_scan_driver #(
        .DIGITS       (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .blank_lz     (blank_lz),
        .digit_out    (digit_out),
        .digit_sel    (digit_sel),
        .digit_blank  (digit_blank),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            mon_cycles++;
            if ($countones(~digit_sel) > 1) mon_viol++;
            if (dut.r_state == GUARD && digit_sel !== 4'b1111) mon_viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_done();
        for (int k = 0; k < 60 && frame_done !== 1'b1; k++) tick();
        if (frame_done !== 1'b1) begin
            n_checks++;
            $display("FAIL frame_done_timeout: got %b required 1", frame_done);
        end
    endtask

    // Watches the 20 cycles after a frame_done sample and drops value_valid once accepted.
    task automatic observe_frame();
        logic acc;
        for (int i = 0; i < 4; i++) begin
            obs_nib[i] = 4'hx;
            obs_cnt[i] = 0;
        end
        obs_blank = 4'hx;
        obs_guard = 0; obs_unstable = 0; obs_fd = 0; obs_fd_pos = -1;
        obs_acc = 0; obs_ready_low = 0;
        for (int c = 0; c < 20; c++) begin
            acc = value_valid && value_ready;
            tick();
            if (acc) begin
                value_valid = 1'b0;
                obs_acc++;
            end
            if (value_ready !== 1'b1) obs_ready_low++;
            if (frame_done === 1'b1) begin
                obs_fd++;
                obs_fd_pos = c;
            end
            if (digit_sel === 4'b1111) begin
                obs_guard++;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (digit_sel[i] === 1'b0) begin
                        if (obs_cnt[i] == 0) begin
                            obs_nib[i]   = digit_out;
                            obs_blank[i] = digit_blank;
                        end else if (digit_out !== obs_nib[i] || digit_blank !== obs_blank[i]) begin
                            obs_unstable++;
                        end
                        obs_cnt[i]++;
                    end
                end
            end
        end
        obs_val = {obs_nib[3], obs_nib[2], obs_nib[1], obs_nib[0]};
        obs_timing_ok = (obs_cnt[0] == 4) && (obs_cnt[1] == 4) && (obs_cnt[2] == 4) &&
                        (obs_cnt[3] == 4) && (obs_guard == 4) && (obs_unstable == 0) &&
                        (obs_fd == 1) && (obs_fd_pos == 19);
    endtask

    task automatic test_reset_values();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({digit_sel, digit_out, digit_blank, frame_done, value_ready} !== {4'b1111, 4'h0, 1'b1, 1'b0, 1'b1})
            $display("FAIL reset_values: got sel=%b out=%h blank=%b fd=%b rdy=%b required 1111 0 1 0 1",
                     digit_sel, digit_out, digit_blank, frame_done, value_ready);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_display();
        value_in = 16'h3A7F;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        n_checks++;
        if (value_ready !== 1'b0) $display("FAIL disp_accept: got ready=%b required 0", value_ready);
        else n_pass++;
        wait_frame_done();
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h3A7F) $display("FAIL disp_value: got %h required 3a7f", obs_val);
        else n_pass++;
        n_checks++;
        if (obs_blank !== 4'b0000) $display("FAIL disp_blank: got %b required 0000", obs_blank);
        else n_pass++;
        n_checks++;
        if (obs_timing_ok !== 1'b1)
            $display("FAIL disp_timing: got cnt=%0d,%0d,%0d,%0d guard=%0d unstable=%0d fd=%0d@%0d required 4,4,4,4 4 0 1@19",
                     obs_cnt[0], obs_cnt[1], obs_cnt[2], obs_cnt[3], obs_guard, obs_unstable, obs_fd, obs_fd_pos);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drive();
        tick();
        value_in = 16'hBEEF;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        tick();
        n_checks++;
        if (value_ready !== 1'b0 || digit_sel !== 4'b1110)
            $display("FAIL pre_reset: got rdy=%b sel=%b required 0 1110", value_ready, digit_sel);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({digit_sel, digit_blank, value_ready, frame_done, digit_out} !== {4'b1111, 1'b1, 1'b1, 1'b0, 4'h0})
            $display("FAIL async_reset: got sel=%b blank=%b rdy=%b fd=%b out=%h required 1111 1 1 0 0",
                     digit_sel, digit_blank, value_ready, frame_done, digit_out);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({digit_sel, digit_out, digit_blank} !== {4'b1110, 4'h0, 1'b0})
            $display("FAIL first_drive: got sel=%b out=%h blank=%b required 1110 0 0", digit_sel, digit_out, digit_blank);
        else n_pass++;
        wait_frame_done();
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h0000) $display("FAIL reset_discard: got %h required 0000", obs_val);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ready_high;
        tick();
        value_in = 16'h1111;
        value_valid = 1'b1;
        tick();
        n_checks++;
        if (value_ready !== 1'b0) $display("FAIL b2b_first_accept: got ready=%b required 0", value_ready);
        else n_pass++;
        value_in = 16'h2222;
        ready_high = 0;
        for (int k = 0; k < 60 && frame_done !== 1'b1; k++) begin
            tick();
            if (value_ready !== 1'b0) ready_high++;
        end
        n_checks++;
        if (frame_done !== 1'b1 || ready_high != 0)
            $display("FAIL b2b_hold: got fd=%b ready_high_cycles=%0d required 1 0", frame_done, ready_high);
        else n_pass++;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h1111 || obs_timing_ok !== 1'b1)
            $display("FAIL b2b_frame1: got %h timing_ok=%b required 1111 1", obs_val, obs_timing_ok);
        else n_pass++;
        n_checks++;
        if (obs_acc != 1) $display("FAIL b2b_second_accept: got %0d accepts required 1", obs_acc);
        else n_pass++;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h2222 || obs_timing_ok !== 1'b1 || obs_ready_low != 0)
            $display("FAIL b2b_frame2: got %h timing_ok=%b ready_low=%0d required 2222 1 0",
                     obs_val, obs_timing_ok, obs_ready_low);
        else n_pass++;
    endtask

    task automatic test_boundary_transfer();
        n_checks++;
        if (frame_done !== 1'b1 || value_ready !== 1'b1)
            $display("FAIL edge_precond: got fd=%b rdy=%b required 1 1", frame_done, value_ready);
        else n_pass++;
        value_in = 16'h0042;
        value_valid = 1'b1;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h0042 || obs_blank !== 4'b0000)
            $display("FAIL edge_direct: got %h blank=%b required 0042 0000", obs_val, obs_blank);
        else n_pass++;
        n_checks++;
        if (obs_ready_low != 0 || obs_acc != 1)
            $display("FAIL edge_ready: got ready_low=%0d accepts=%0d required 0 1", obs_ready_low, obs_acc);
        else n_pass++;
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h0042 || obs_blank !== 4'b1100)
            $display("FAIL lz_0042: got %h blank=%b required 0042 1100", obs_val, obs_blank);
        else n_pass++;
        value_in = 16'h0000;
        value_valid = 1'b1;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h0000 || obs_blank !== 4'b1110)
            $display("FAIL lz_0000: got %h blank=%b required 0000 1110", obs_val, obs_blank);
        else n_pass++;
        value_in = 16'h0100;
        value_valid = 1'b1;
        observe_frame();
        n_checks++;
        if (obs_val !== 16'h0100 || obs_blank !== 4'b1000)
            $display("FAIL lz_0100: got %h blank=%b required 0100 1000", obs_val, obs_blank);
        else n_pass++;
        blank_lz = 1'b0;
        tick();
    endtask

    task automatic test_select_monitor();
        n_checks++;
        if (mon_viol != 0 || mon_cycles == 0)
            $display("FAIL sel_monitor: got violations=%0d cycles=%0d required 0 >0", mon_viol, mon_cycles);
        else n_pass++;
    endtask

    initial begin
        test_reset_values();
        test_display();
        test_reset_mid_drive();
        test_back_to_back();
        test_boundary_transfer();
        test_blank_lz();
        test_select_monitor();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
